// File: rtl/bft_leaf_packer.sv
// BFT leaf packer: pops an FWFT FIFO and frames each word as a NoC leaf packet.
// One registered output stage, burst-limited so a leaf cannot hog the switch.
module bft_leaf_packer #(
    parameter int DSIZE     = 32,
    parameter int ADDR_W    = 5,
    parameter int PORT_W    = 5,
    parameter int MAX_BURST = 8,
    parameter int PKT_W     = 1 + ADDR_W + PORT_W + DSIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] dest_leaf,
    input  logic [PORT_W-1:0] dest_port,
    input  logic [DSIZE-1:0]  fifo_rdata,
    input  logic              fifo_rempty,
    output logic              fifo_rinc,
    output logic [PKT_W-1:0]  out_pkt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       pkt_count,
    output logic              busy
);

    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         burst_q, burst_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic               valid_q, valid_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               pop;
    logic               accept;
    logic               stall;
    logic [7:0]         burst_inc;

    // rst_n gates the strobe so nothing is lost from the FIFO during reset
    assign pop = rst_n & en & ~fifo_rempty & (state_q != GAP)
               & (~valid_q | out_ready);
    assign accept    = valid_q & out_ready;
    assign stall     = valid_q & ~out_ready;
    assign burst_inc = burst_q + 8'd1;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE, STREAM: begin
                if (pop) begin
                    if (burst_inc == MAXB) begin
                        state_d = GAP;
                        burst_d = 8'd0;
                    end else begin
                        state_d = STREAM;
                        burst_d = burst_inc;
                    end
                end else if (!stall) begin
                    state_d = IDLE;
                    burst_d = 8'd0;
                end
            end
            GAP: begin
                state_d = IDLE;
                burst_d = 8'd0;
            end
            default: begin
                state_d = IDLE;
                burst_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        pkt_d   = pkt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q + {15'd0, accept};
        if (pop) begin
            pkt_d   = {1'b1, dest_leaf, dest_port, fifo_rdata};
            valid_d = 1'b1;
        end else if (accept) begin
            pkt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            burst_q <= 8'd0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_rinc = pop;
    assign out_pkt   = pkt_q;
    assign out_valid = valid_q;
    assign pkt_count = cnt_q;
    assign busy      = (state_q != IDLE) | valid_q;

endmodule

// File: tb/tb_bft_leaf_packer.sv
// Bench for bft_leaf_packer: FIFO emulation, packet-level model,
// per-cycle compare plus directed literal checks.
module tb_bft_leaf_packer;

    localparam int DSIZE = 32;
    localparam int AW    = 5;
    localparam int PW    = 5;
    localparam int MAXB  = 8;
    localparam int PKT_W = 1 + AW + PW + DSIZE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [AW-1:0]    dest_leaf;
    logic [PW-1:0]    dest_port;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [PKT_W-1:0] out_pkt;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      pkt_count;
    logic             busy;

    bft_leaf_packer #(
        .DSIZE(DSIZE), .ADDR_W(AW), .PORT_W(PW), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .dest_leaf(dest_leaf), .dest_port(dest_port),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
        .fifo_rinc(fifo_rinc), .out_pkt(out_pkt),
        .out_valid(out_valid), .out_ready(out_ready),
        .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // bench-side FIFO contents
    logic [DSIZE-1:0] q[$];

    // packet-level model: output slot, accept count, burst run length
    logic             m_valid = 1'b0;
    logic [PKT_W-1:0] m_pkt   = '0;
    logic [15:0]      m_cnt   = 16'd0;
    int               m_run   = 0;
    logic             m_gap   = 1'b0;

    logic             last_rinc;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic refresh();
        fifo_rempty = (q.size() == 0);
        fifo_rdata  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        q.push_back(w);
        refresh();
    endtask

    // one clock: compare at negedge, advance model and FIFO at posedge
    task automatic step();
        logic exp_pop, acc, stl;
        logic [PKT_W-1:0] np;
        @(negedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_pkt   = '0;
            m_cnt   = 16'd0;
            m_run   = 0;
            m_gap   = 1'b0;
        end
        exp_pop = rst_n && en && (q.size() > 0) && !m_gap
                  && (!m_valid || out_ready);
        chk("rinc",  {63'd0, fifo_rinc}, {63'd0, exp_pop});
        chk("valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("pkt",   64'(out_pkt), 64'(m_pkt));
        chk("count", 64'(pkt_count), 64'(m_cnt));
        chk("busy",  {63'd0, busy},
            {63'd0, m_valid || (m_run > 0) || m_gap});
        last_rinc = fifo_rinc;
        np = {1'b1, dest_leaf, dest_port,
              (q.size() != 0) ? q[0] : {DSIZE{1'b0}}};
        acc = m_valid && out_ready;
        stl = m_valid && !out_ready;
        @(posedge clk);
        if (rst_n) begin
            if (acc) m_cnt = m_cnt + 16'd1;
            if (exp_pop) begin
                m_pkt   = np;
                m_valid = 1'b1;
                m_run   = m_run + 1;
                m_gap   = (m_run == MAXB);
                if (m_gap) m_run = 0;
            end else begin
                if (acc) begin
                    m_valid = 1'b0;
                    m_pkt   = '0;
                end
                m_gap = 1'b0;
                if (!stl) m_run = 0;
            end
        end
        if (last_rinc && q.size() > 0) void'(q.pop_front());
        #1;
        refresh();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (q.size() > 0 || out_valid); i++)
            step();
        chk("drained", {63'd0, q.size() == 0 && !out_valid}, 64'd1);
        step();
    endtask

    localparam logic [PKT_W-1:0] PKT_SINGLE =
        {1'b1, 5'd3, 5'd1, 32'hDEADBEEF};
    localparam logic [PKT_W-1:0] PKT_BP =
        {1'b1, 5'd7, 5'd2, 32'h1111_0001};

    logic [21:0] mask;

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        dest_leaf = '0;
        dest_port = '0;
        refresh();
        step();
        step();
        rst_n = 1'b1;
        step();

        // single word
        dest_leaf = 5'd3;
        dest_port = 5'd1;
        en = 1'b1;
        out_ready = 1'b1;
        push(32'hDEADBEEF);
        step();
        chk("single_pop", {63'd0, last_rinc}, 64'd1);
        chk("single_pkt", 64'(out_pkt), 64'(PKT_SINGLE));
        chk("single_vld", {63'd0, out_valid}, 64'd1);
        step();
        chk("single_pop2", {63'd0, last_rinc}, 64'd0);
        chk("single_cnt", 64'(pkt_count), 64'd1);
        drain(20);

        // backpressure
        dest_leaf = 5'd7;
        dest_port = 5'd2;
        out_ready = 1'b0;
        push(32'h1111_0001);
        push(32'h1111_0002);
        push(32'h1111_0003);
        step();
        chk("bp_pop", {63'd0, last_rinc}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_nopop", {63'd0, last_rinc}, 64'd0);
            chk("bp_hold", 64'(out_pkt), 64'(PKT_BP));
        end
        out_ready = 1'b1;
        step();
        chk("bp_rel1", {63'd0, last_rinc}, 64'd1);
        step();
        chk("bp_rel2", {63'd0, last_rinc}, 64'd1);
        step();
        chk("bp_rel3", {63'd0, last_rinc}, 64'd0);
        drain(20);
        chk("bp_cnt", 64'(pkt_count), 64'd4);

        // burst limit
        dest_leaf = 5'd31;
        dest_port = 5'd31;
        for (int i = 0; i < 20; i++) push(32'hB000_0000 + 32'(i));
        mask = '0;
        for (int i = 0; i < 22; i++) begin
            step();
            mask[i] = last_rinc;
        end
        chk("burst_mask", 64'(mask), 64'h3DFEFF);
        drain(20);
        chk("burst_cnt", 64'(pkt_count), 64'd24);

        // enable toggle
        dest_leaf = 5'd0;
        dest_port = 5'd17;
        for (int i = 0; i < 4; i++) push(32'hE000_0000 + 32'(i));
        step();
        chk("en_pop1", {63'd0, last_rinc}, 64'd1);
        step();
        chk("en_pop2", {63'd0, last_rinc}, 64'd1);
        en = 1'b0;
        step();
        chk("en_off_pop", {63'd0, last_rinc}, 64'd0);
        chk("en_off_acc", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("en_off_pop", {63'd0, last_rinc}, 64'd0);
        end
        en = 1'b1;
        step();
        chk("en_resume", {63'd0, last_rinc}, 64'd1);
        drain(20);
        chk("en_cnt", 64'(pkt_count), 64'd28);

        // async reset mid-stream
        for (int i = 0; i < 4; i++) push(32'hC000_0000 + 32'(i));
        step();
        step();
        chk("rst_pre_vld", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_vld", {63'd0, out_valid}, 64'd0);
        chk("rst_pkt", 64'(out_pkt), 64'd0);
        chk("rst_cnt", 64'(pkt_count), 64'd0);
        chk("rst_rinc", {63'd0, fifo_rinc}, 64'd0);
        step();
        rst_n = 1'b1;
        drain(20);
        chk("rst_after_cnt", 64'(pkt_count), 64'd2);

        // counter wrap over 65536 accepts
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) q.push_back(32'(i));
        refresh();
        drain(80000);
        chk("wrap_cnt", 64'(pkt_count), 64'd0);
        chk("wrap_vld", {63'd0, out_valid}, 64'd0);
        chk("wrap_busy", {63'd0, busy}, 64'd0);
        push(32'h0000_00AA);
        drain(20);
        chk("wrap_next", 64'(pkt_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
